// File: rtl/reg_read_scoreboard_pkg.sv
// Shared types for the register-read scoreboard: address and counter widths
// for the default RV32 configuration.
package RafiTypes;

  localparam int RAFI_NUM_REGS = 32;
  localparam int RAFI_ADDR_W   = 5;
  localparam int RAFI_CNT_W    = 2;

  typedef logic [RAFI_ADDR_W-1:0] RegAddrPath;
  typedef logic [RAFI_CNT_W-1:0]  ScoreCount;

  localparam ScoreCount SCORE_MAX = '1;

endpackage

// File: rtl/reg_read_scoreboard_pending_counters.sv
// Per-register pending-writer counters for one register file; increments on
// issue, decrements on writeback, clears on flush.
module reg_pending_counters
  import RafiTypes::*;
#(
  parameter int NUM_REGS   = RAFI_NUM_REGS,
  parameter int ADDR_W     = RAFI_ADDR_W,
  parameter int CNT_W      = RAFI_CNT_W,
  parameter bit ignoreZero = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              incValid,
  input  logic [ADDR_W-1:0] incAddr,
  input  logic              decValid,
  input  logic [ADDR_W-1:0] decAddr,
  output logic [CNT_W-1:0]  count [NUM_REGS],
  output logic [NUM_REGS-1:0] busy,
  output logic              underflow
);

  logic [NUM_REGS-1:0] incHit;
  logic [NUM_REGS-1:0] decHit;

  always_comb begin
    incHit    = '0;
    decHit    = '0;
    busy      = '0;
    underflow = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      // Register 0 of the int file is hardwired and never tracked.
      if (!(ignoreZero && i == 0)) begin
        incHit[i] = incValid && (incAddr == ADDR_W'(i));
        decHit[i] = decValid && (decAddr == ADDR_W'(i));
      end
      busy[i] = |count[i];
      if (decHit[i] && !incHit[i] && count[i] == '0 && !flush)
        underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst || flush)
        count[i] <= '0;
      else if (incHit[i] && !decHit[i])
        count[i] <= count[i] + 1'b1;
      else if (decHit[i] && !incHit[i] && count[i] != '0)
        count[i] <= count[i] - 1'b1;
    end
  end

endmodule

// File: rtl/reg_read_scoreboard.sv
// Register-read scoreboard: stalls decode while any source has a pending
// writer or the destination's writer count is saturated.
module reg_read_scoreboard
  import RafiTypes::*;
#(
  parameter int NUM_REGS = RAFI_NUM_REGS,
  parameter int ADDR_W   = RAFI_ADDR_W,
  parameter int CNT_W    = RAFI_CNT_W,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                downstreamStall,
  input  logic                opValid,
  input  logic [ADDR_W-1:0]   rs1Addr,
  input  logic [ADDR_W-1:0]   rs2Addr,
  input  logic [ADDR_W-1:0]   rs3Addr,
  input  logic                rs1IsInt,
  input  logic                rs1IsFp,
  input  logic                rs2IsInt,
  input  logic                rs2IsFp,
  input  logic                rs3IsFp,
  input  logic [ADDR_W-1:0]   rdAddr,
  input  logic                rdIsInt,
  input  logic                rdIsFp,
  input  logic                intWbValid,
  input  logic [ADDR_W-1:0]   intWbAddr,
  input  logic                fpWbValid,
  input  logic [ADDR_W-1:0]   fpWbAddr,
  output logic                rrStall,
  output logic                issue,
  output logic [NUM_REGS-1:0] intBusy,
  output logic [NUM_REGS-1:0] fpBusy,
  output logic                underflowErr,
  output logic [PERF_W-1:0]   stallCycles
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [CNT_W-1:0] intCnt [NUM_REGS];
  logic [CNT_W-1:0] fpCnt  [NUM_REGS];
  logic             intUf;
  logic             fpUf;
  logic             srcHz;
  logic             dstSat;
  logic             hazard;

  // Hazards look only at registered counts: a writeback this cycle does not
  // release a reader until the next cycle.
  always_comb begin
    srcHz = (rs1IsInt && rs1Addr != '0 && intCnt[rs1Addr] != '0) ||
            (rs1IsFp  && fpCnt[rs1Addr] != '0) ||
            (rs2IsInt && rs2Addr != '0 && intCnt[rs2Addr] != '0) ||
            (rs2IsFp  && fpCnt[rs2Addr] != '0) ||
            (rs3IsFp  && fpCnt[rs3Addr] != '0);
    if (rdIsInt)
      dstSat = (rdAddr != '0) && (intCnt[rdAddr] == CNT_SAT);
    else
      dstSat = rdIsFp && (fpCnt[rdAddr] == CNT_SAT);
    hazard = opValid && (srcHz || dstSat);
  end

  assign rrStall = hazard | downstreamStall;
  assign issue   = opValid & ~rrStall & ~flush;

  reg_pending_counters #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ignoreZero(1'b1)
  ) intCounters (
    .clk(clk), .rst(rst), .flush(flush),
    .incValid(issue & rdIsInt), .incAddr(rdAddr),
    .decValid(intWbValid), .decAddr(intWbAddr),
    .count(intCnt), .busy(intBusy), .underflow(intUf)
  );

  // An op flagged for both files is tracked only in the int file.
  reg_pending_counters #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ignoreZero(1'b0)
  ) fpCounters (
    .clk(clk), .rst(rst), .flush(flush),
    .incValid(issue & rdIsFp & ~rdIsInt), .incAddr(rdAddr),
    .decValid(fpWbValid), .decAddr(fpWbAddr),
    .count(fpCnt), .busy(fpBusy), .underflow(fpUf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      underflowErr <= 1'b0;
      stallCycles  <= '0;
    end else begin
      if (intUf || fpUf)
        underflowErr <= 1'b1;
      if (hazard && !flush)
        stallCycles <= stallCycles + 1'b1;
    end
  end

endmodule

// File: doc/reg_read_scoreboard.md
Name: reg_read_scoreboard

Overview:
- Register-dependency scoreboard and stall generator for the register-read stage of the in-order RV32 pipeline.
- Counts in-flight writers per integer and FP architectural register.
- Stalls the decode-to-register-read hand-off while any source operand still has a pending writer.
- Drives the rrStall input of the register-read stage and clears all tracking on pipeline flush.

Parameters:
NUM_REGS, 32, architectural registers per file (int and fp each)
ADDR_W, 5, register address width (log2 NUM_REGS)
CNT_W, 2, width of each per-register pending-writer counter
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush from main controller
downstreamStall  in  1  stall request from execute/later stages
opValid  in  1  decode-stage op valid
rs1Addr  in  ADDR_W  source 1 address
rs2Addr  in  ADDR_W  source 2 address
rs3Addr  in  ADDR_W  source 3 address (fp only)
rs1IsInt  in  1  rs1 read from int file
rs1IsFp  in  1  rs1 read from fp file
rs2IsInt  in  1  rs2 read from int file
rs2IsFp  in  1  rs2 read from fp file
rs3IsFp  in  1  rs3 read from fp file
rdAddr  in  ADDR_W  destination address
rdIsInt  in  1  op writes int file
rdIsFp  in  1  op writes fp file
intWbValid  in  1  int register file write this cycle
intWbAddr  in  ADDR_W  int write address
fpWbValid  in  1  fp register file write this cycle
fpWbAddr  in  ADDR_W  fp write address
rrStall  out  1  hold register-read stage and upstream
issue  out  1  op accepted into register-read this cycle
intBusy  out  NUM_REGS  per-register nonzero-count vector, int
fpBusy  out  NUM_REGS  per-register nonzero-count vector, fp
underflowErr  out  1  sticky: writeback to a register with count 0
stallCycles  out  PERF_W  cycles with hazard-caused stall

Behaviour:
- Reset: all counters 0; intBusy=fpBusy=0; underflowErr=0; stallCycles=0.
  - rrStall=0 and issue=0 follow combinationally while opValid=0.
- State: int counter array and fp counter array, NUM_REGS x CNT_W each.
  - Int x0 is never counted: issue and writeback to int x0 are ignored, and int x0 reads never hazard. FP f0 is an ordinary register.
- Hazard (combinational, from registered counts only):
  - opValid and any enabled source whose file's count at that address is nonzero.
  - Or the destination count equals 2^CNT_W-1 (saturated).
  - No same-cycle writeback bypass: a register written this cycle still hazards this cycle. The stall releases the cycle after the writeback.
- rrStall = hazard | downstreamStall.
- issue = opValid & ~rrStall & ~flush.
- Counter update per register, per cycle:
  - +1 if issue targets it, -1 if writeback targets it.
  - Both together: unchanged.
  - Writeback to count 0: count stays 0 and underflowErr sets; it clears only on rst.
- flush: all counters become 0 next cycle, and issue and writebacks in that cycle are ignored.
  - Flush is raised only at commit, after all older writers have written back, so every remaining entry belongs to a squashed op.
- rdIsInt and rdIsFp are mutually exclusive. If both are set, only int is tracked.
- stallCycles increments on cycles with opValid & hazard & ~flush, and wraps at 2^PERF_W.
- Latency: counts update one cycle after issue/writeback. The busy vectors are registered-equivalent (OR-reduce of the counters).
- Reset mid-operation takes priority over flush, issue and writeback.

Decomposition:
- Shared package (RafiTypes):
  - RegAddrPath typedef
  - ScoreCount typedef (CNT_W)
  - SCORE_MAX constant
- Sub-module reg_pending_counters: one instance per register file. It holds the counter array, the inc/dec/clear logic and the busy-vector output, with an ignoreZero parameter (1 for int, 0 for fp).
- The top level contains hazard detection, issue logic and the perf counter.

Test Plan:
- Reset → intBusy=0, fpBusy=0, rrStall=0, stallCycles=0. opValid=1 with rs1=x3 → issue=1.
- Issue rd=x5 int; next op rs1=x5 int → rrStall=1 each cycle; intWbValid with addr 5 at cycle 4 → rrStall=0 at cycle 5, issue=1, stallCycles=3.
- Issue rd=x0 → intBusy=0. Op reading rs1=x0, rs2=x0 → rrStall=0.
- Two issues rd=f3 → fpBusy[3]=1, count 2. One fpWb f3 → still stalls a reader of f3. Second fpWb → fpBusy[3]=0.
- CNT_W=2: three issues rd=x7 → count 3. Fourth op with rd=x7 → rrStall=1 until one wb to x7.
- Counts pending on x9/f2 plus flush with concurrent issue and wb → next cycle all busy=0 and issue=0 during flush. Later intWb x9 → underflowErr=1 and stays 1.
